// File: rtl/pro_seg_pkg.sv
// Shared encodings for the paged 7-segment controller: display modes, glyph codes, FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package pro_seg_pkg;

  typedef enum logic [1:0] {
    MODE_DEC  = 2'd0,
    MODE_LZB  = 2'd1,
    MODE_HEX  = 2'd2,
    MODE_DASH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam logic [4:0] GLY_BLANK = 5'd16;
  localparam logic [4:0] GLY_DASH  = 5'd17;

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/pro_seg_glyph.sv
// Glyph code to active-high segments (bit order g..a); purely combinational, zero latency.
// No flow control: codes 0-15 are hex glyphs, GLY_DASH lights g only, anything else is blank.
module pro_seg_glyph
  import pro_seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (code)
      5'd0:     seg = 7'h3F;
      5'd1:     seg = 7'h06;
      5'd2:     seg = 7'h5B;
      5'd3:     seg = 7'h4F;
      5'd4:     seg = 7'h66;
      5'd5:     seg = 7'h6D;
      5'd6:     seg = 7'h7D;
      5'd7:     seg = 7'h07;
      5'd8:     seg = 7'h7F;
      5'd9:     seg = 7'h6F;
      5'd10:    seg = 7'h77;
      5'd11:    seg = 7'h7C;
      5'd12:    seg = 7'h39;
      5'd13:    seg = 7'h5E;
      5'd14:    seg = 7'h79;
      5'd15:    seg = 7'h71;
      GLY_DASH: seg = 7'h40;
      default:  seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/pro_seg_display_ctrl.sv
// Binary to paged 7-segment display: bit-serial double-dabble, valid DATA_W+1 cycles after a DEC load,
// 1 cycle after HEX/DASH. No queueing: loads arriving while a conversion or latch is pending are dropped.
module pro_seg_display_ctrl
  import pro_seg_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DIGITS     = 4,
  parameter int NBCD       = 2 * DIGITS,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 1,
  parameter int ACTIVE_LOW = 1
)(
  input  logic                  clk_50M,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  input  logic [1:0]            mode,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int NHEX  = (DATA_W + 3) / 4;
  localparam int NP0   = (NBCD > 2 * DIGITS) ? NBCD : 2 * DIGITS;
  localparam int NP    = (NP0 > NHEX) ? NP0 : NHEX;
  localparam logic [7*DIGITS-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  state_e                  state, state_nxt;
  logic                    capture;
  mode_e                   mode_q;
  logic [DATA_W-1:0]       bin;
  logic [4*NBCD-1:0]       bcd, bcd_adj;
  logic [CNT_W-1:0]        cnt;
  logic [PRE_W-1:0]        pre;
  logic                    phase, toggle;
  logic [DIGITS-1:0][4:0]  codes0, codes1, new0, new1, show;
  logic                    new_ovf, seen0, seen1;
  logic [4*NP-1:0]         bcd_pad, hex_pad;
  logic [7*DIGITS-1:0]     seg_raw;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: if (load) begin
        capture   = 1'b1;
        state_nxt = (mode >= MODE_HEX) ? ST_LATCH : ST_CONV;
      end
      ST_CONV:  if (cnt == CNT_W'(DATA_W - 1)) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NBCD; i++) bcd_adj[4*i +: 4] = dabble_adj(bcd[4*i +: 4]);
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      mode_q <= MODE_DEC;
      busy   <= 1'b0;
    end else begin
      if (capture) begin
        bin    <= data;
        bcd    <= '0;
        cnt    <= '0;
        mode_q <= mode_e'(mode);
      end else if (state == ST_CONV) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        cnt        <= cnt + 1'b1;
      end
      busy <= (state == ST_CONV);
    end
  end

  // Build both pages from the finished conversion (or raw nibbles); page 1 always drops leading zeros.
  always_comb begin
    bcd_pad = '0;
    bcd_pad[4*NBCD-1:0] = bcd;
    hex_pad = '0;
    hex_pad[DATA_W-1:0] = bin;
    new_ovf = 1'b0;
    new0    = '0;
    new1    = '0;
    seen0   = 1'b0;
    seen1   = 1'b0;
    case (mode_q)
      MODE_DASH: begin
        for (int i = 0; i < DIGITS; i++) begin
          new0[i] = GLY_DASH;
          new1[i] = GLY_DASH;
        end
      end
      MODE_HEX: begin
        new_ovf = (NHEX > DIGITS) ? 1'b1 : 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
          new0[i] = (i < NHEX) ? {1'b0, hex_pad[4*i +: 4]} : GLY_BLANK;
          new1[i] = {1'b0, hex_pad[4*(DIGITS+i) +: 4]};
        end
      end
      default: begin
        for (int i = DIGITS; i < NBCD; i++)
          if (bcd_pad[4*i +: 4] != 4'd0) new_ovf = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          new0[i] = {1'b0, bcd_pad[4*i +: 4]};
          new1[i] = {1'b0, bcd_pad[4*(DIGITS+i) +: 4]};
        end
      end
    endcase
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen1 = seen1 | (new1[i] != 5'd0) | (i == 0);
      if (!seen1) new1[i] = GLY_BLANK;
      seen0 = seen0 | (new0[i] != 5'd0) | (i == 0);
      if (mode_q == MODE_LZB && !new_ovf && !seen0) new0[i] = GLY_BLANK;
    end
  end

  assign toggle = (state != ST_LATCH) && (pre == PRE_W'(HALF - 1));

  // Selects what the display shows after this edge, i.e. using the phase about to be entered.
  always_comb begin
    show = codes0;
    if (state == ST_LATCH)                show = new0;
    else if (overflow && !phase)          show = codes1;
    else if (!overflow && blink_en && !phase)
      for (int i = 0; i < DIGITS; i++) show[i] = GLY_BLANK;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    pro_seg_glyph u_glyph (
      .code (show[g]),
      .seg  (seg_raw[7*g +: 7])
    );
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      codes0   <= {DIGITS{GLY_BLANK}};
      codes1   <= {DIGITS{GLY_BLANK}};
      overflow <= 1'b0;
      valid    <= 1'b0;
      pre      <= '0;
      phase    <= 1'b0;
      seg      <= SEG_OFF;
    end else begin
      valid <= (state == ST_LATCH);
      if (state == ST_LATCH) begin
        codes0   <= new0;
        codes1   <= new1;
        overflow <= new_ovf;
        pre      <= '0;
        phase    <= 1'b0;
      end else if (toggle) begin
        pre   <= '0;
        phase <= ~phase;
      end else begin
        pre <= pre + 1'b1;
      end
      if (state == ST_LATCH || toggle)
        seg <= (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end
  end

endmodule

// File: tb/tb_pro_seg_display_ctrl.sv
// Directed bench for pro_seg_display_ctrl with a cycle-level arithmetic model compared every cycle.
// Runs DATA_W=16, DIGITS=4, CLK_HZ=100 so a blink half-period is 50 cycles.
module tb_pro_seg_display_ctrl;

  localparam int HALF = 50;
  localparam logic [27:0] SEG_OFF = '1;

  logic        clk_50M = 1'b0;
  logic        rst, load, blink_en, busy, valid, overflow;
  logic [15:0] data;
  logic [1:0]  mode;
  logic [27:0] seg;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  pro_seg_display_ctrl #(
    .DATA_W(16), .DIGITS(4), .NBCD(8), .CLK_HZ(100), .BLINK_HZ(1), .ACTIVE_LOW(1)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .mode     (mode),
    .blink_en (blink_en),
    .busy     (busy),
    .valid    (valid),
    .overflow (overflow),
    .seg      (seg)
  );

  always #5 clk_50M = ~clk_50M;

  logic [6:0] gtab [0:17] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                              7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00, 7'h40};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] render(input logic [3:0][4:0] c);
    logic [27:0] s;
    s = '0;
    for (int j = 0; j < 4; j++) s[7*j +: 7] = ~gtab[c[j]];
    return s;
  endfunction

  // Expected pages straight from decimal/hex arithmetic on the loaded value.
  task automatic make_pages(input int unsigned v, input int m, output logic [3:0][4:0] p0,
                            output logic [3:0][4:0] p1, output logic ov);
    int unsigned pw;
    ov = 1'b0;
    for (int j = 0; j < 4; j++) begin
      p0[j] = 5'd16;
      p1[j] = 5'd16;
    end
    if (m == 3) begin
      for (int j = 0; j < 4; j++) p0[j] = 5'd17;
    end else if (m == 2) begin
      for (int j = 0; j < 4; j++) p0[j] = 5'((v >> (4*j)) & 15);
    end else begin
      ov = (v >= 10000);
      pw = 1;
      for (int j = 0; j < 4; j++) begin
        p0[j] = 5'((v / pw) % 10);
        if (m == 1 && !ov && j > 0 && v < pw) p0[j] = 5'd16;
        pw = pw * 10;
      end
      for (int j = 0; j < 4; j++) begin
        p1[j] = 5'((v / pw) % 10);
        if (j > 0 && v < pw) p1[j] = 5'd16;
        pw = pw * 10;
      end
    end
  endtask

  logic [3:0][4:0] m_p0, m_p1, n_p0, n_p1;
  logic            m_ovf, n_ovf, m_valid, m_busy, m_pend, m_dec, was_pend, odd;
  logic [27:0]     m_seg;
  int              cyc, m_acc, m_lat, m_since;

  always @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_dec = 1'b0;
      m_since = 0; cyc = 0; m_acc = 0; m_lat = 0;
      for (int j = 0; j < 4; j++) begin
        m_p0[j] = 5'd16;
        m_p1[j] = 5'd16;
      end
      m_seg = SEG_OFF;
    end else begin
      was_pend = m_pend;
      cyc++;
      m_valid = 1'b0;
      if (m_pend && cyc == m_lat) begin
        m_p0 = n_p0; m_p1 = n_p1; m_ovf = n_ovf;
        m_since = 0; m_seg = render(m_p0); m_valid = 1'b1; m_pend = 1'b0;
      end else begin
        m_since++;
        if (m_since % HALF == 0) begin
          odd = ((m_since / HALF) % 2) == 1;
          if (m_ovf)               m_seg = render(odd ? m_p1 : m_p0);
          else if (blink_en && odd) m_seg = SEG_OFF;
          else                      m_seg = render(m_p0);
        end
      end
      if (load && !was_pend) begin
        make_pages(32'(data), int'(mode), n_p0, n_p1, n_ovf);
        m_pend = 1'b1;
        m_dec  = (mode < 2'd2);
        m_acc  = cyc;
        m_lat  = cyc + (m_dec ? 17 : 1);
      end
      m_busy = m_pend && m_dec && (cyc > m_acc);
    end
  end

  always @(negedge clk_50M) begin
    if (chk_on) begin
      chk("model_busy", 64'(busy), 64'(m_busy));
      chk("model_valid", 64'(valid), 64'(m_valid));
      chk("model_overflow", 64'(overflow), 64'(m_ovf));
      chk("model_seg", 64'(seg), 64'(m_seg));
    end
  end

  task automatic pulse(input logic [15:0] v, input logic [1:0] m);
    @(negedge clk_50M);
    load = 1'b1; data = v; mode = m;
    @(negedge clk_50M);
    load = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk_50M);
      n++;
    end
  endtask

  int n;

  initial begin
    load = 1'b0; data = '0; mode = 2'd0; blink_en = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    #1 chk_on = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_seg", 64'(seg), 64'(SEG_OFF));
    repeat (2) @(negedge clk_50M);
    rst = 1'b0;

    pulse(16'd1234, 2'd0);
    wait_valid(n);
    chk("dec_latency", 64'(n), 64'd17);
    chk("dec_1234", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

    pulse(16'd7, 2'd1);
    wait_valid(n);
    chk("lzb_7", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h78}));
    pulse(16'd0, 2'd1);
    wait_valid(n);
    chk("lzb_0", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    pulse(16'd65535, 2'd0);
    wait_valid(n);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_page0", 64'(seg), 64'({7'h12, 7'h12, 7'h30, 7'h12}));
    repeat (HALF - 1) @(negedge clk_50M);
    chk("ovf_page0_hold", 64'(seg), 64'({7'h12, 7'h12, 7'h30, 7'h12}));
    @(negedge clk_50M);
    chk("ovf_page1", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h02}));

    pulse(16'hBEEF, 2'd2);
    wait_valid(n);
    chk("hex_latency", 64'(n), 64'd1);
    chk("hex_beef", 64'(seg), 64'({7'h03, 7'h06, 7'h06, 7'h0E}));
    chk("hex_no_ovf", 64'(overflow), 64'd0);
    pulse(16'd0, 2'd3);
    wait_valid(n);
    chk("dash", 64'(seg), 64'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));

    blink_en = 1'b1;
    pulse(16'h1234, 2'd2);
    wait_valid(n);
    chk("blink_visible", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
    repeat (HALF) @(negedge clk_50M);
    chk("blink_dark", 64'(seg), 64'(SEG_OFF));
    repeat (HALF) @(negedge clk_50M);
    chk("blink_back", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
    blink_en = 1'b0;

    pulse(16'd1234, 2'd0);
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk_50M);
      n++;
      if (n == 4) begin
        load = 1'b1; data = 16'd999; mode = 2'd2;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    chk("drop_latency", 64'(n), 64'd17);
    chk("drop_value", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19}));

    pulse(16'd4321, 2'd0);
    repeat (7) @(negedge clk_50M);
    @(posedge clk_50M);
    #2 rst = 1'b1;
    #1;
    chk("arst_seg", 64'(seg), 64'(SEG_OFF));
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk_50M);
    rst = 1'b0;
    repeat (20) @(negedge clk_50M);
    chk("arst_no_valid", 64'(seg), 64'(SEG_OFF));
    pulse(16'd9876, 2'd0);
    wait_valid(n);
    chk("post_rst_latency", 64'(n), 64'd17);
    chk("post_rst_9876", 64'(seg), 64'({7'h10, 7'h00, 7'h78, 7'h02}));
    repeat (5) @(negedge clk_50M);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
